// File: rtl/ysyx_24070003_arb_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_24070003_arb_pkg
// Shared types and constants for the ICACHE/LSU read-channel arbiter.
//   arb_state_e : arbiter FSM states (IDLE -> ADDR -> DATA -> IDLE)
//   arb_owner_e : which requester owns the current transaction
//   BURST_INCR  : AXI4 INCR burst encoding
//   SIZE_WORD   : AXI4 4-byte transfer size encoding
// ---------------------------------------------------------------------------
package ysyx_24070003_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IC  = 1'b0,
    OWN_LSU = 1'b1
  } arb_owner_e;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_WORD  = 3'b010;

endpackage

// File: rtl/ysyx_24070003_arb_grant.sv
// ---------------------------------------------------------------------------
// ysyx_24070003_arb_grant
// Priority decision between ICACHE and LSU plus the ICACHE starvation counter.
// The LSU normally wins; once ICACHE has lost STARVE_MAX consecutive
// contested grants it is given the next one.
//   clock, rstn        : clock, synchronous active-low reset
//   idle_i             : arbiter can grant this cycle (FSM idle, not in reset)
//   ic_arvalid_i       : ICACHE request pending
//   lsu_arvalid_i      : LSU request pending
//   grant_ic_o         : ICACHE granted this cycle
//   grant_lsu_o        : LSU granted this cycle
//   winner_o           : owner of the transaction being granted
// ---------------------------------------------------------------------------
module ysyx_24070003_arb_grant
  import ysyx_24070003_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic       clock,
  input  logic       rstn,
  input  logic       idle_i,
  input  logic       ic_arvalid_i,
  input  logic       lsu_arvalid_i,
  output logic       grant_ic_o,
  output logic       grant_lsu_o,
  output arb_owner_e winner_o
);

  localparam int CW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  logic [CW-1:0] starve_q, starve_d;
  logic          ic_prio;

  always_comb begin
    ic_prio     = (starve_q == CW'(STARVE_MAX));
    grant_ic_o  = 1'b0;
    grant_lsu_o = 1'b0;
    if (idle_i) begin
      if (ic_arvalid_i && (ic_prio || !lsu_arvalid_i)) begin
        grant_ic_o = 1'b1;
      end else if (lsu_arvalid_i) begin
        grant_lsu_o = 1'b1;
      end
    end
    winner_o = grant_lsu_o ? OWN_LSU : OWN_IC;

    // Only a loss while ICACHE is actually waiting counts as starvation.
    starve_d = starve_q;
    if (grant_ic_o) begin
      starve_d = '0;
    end else if (grant_lsu_o && ic_arvalid_i && !ic_prio) begin
      starve_d = starve_q + CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!rstn) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/ysyx_24070003_mem_arbiter.sv
// ---------------------------------------------------------------------------
// ysyx_24070003_mem_arbiter
// Shares one AXI4 read port (AR + R) between an ICACHE refill engine and the
// LSU. One transaction at a time: IDLE grants, ADDR presents the latched AR
// fields, DATA routes read beats to the owner until rlast.
//   clock, rstn                      : clock, synchronous active-low reset
//   ic_ar*/ic_r*                     : ICACHE burst read request / data
//   lsu_ar*/lsu_r*                   : LSU single-beat load request / data
//   m_ar*/m_r*                       : shared AXI4 read master channels
//   ic_grant_cnt, lsu_grant_cnt      : wrapping grant counters
// ---------------------------------------------------------------------------
module ysyx_24070003_mem_arbiter
  import ysyx_24070003_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic        clock,
  input  logic        rstn,
  // ICACHE
  input  logic        ic_arvalid,
  input  logic [31:0] ic_araddr,
  input  logic [7:0]  ic_arlen,
  output logic        ic_arready,
  output logic        ic_rvalid,
  output logic [31:0] ic_rdata,
  output logic [1:0]  ic_rresp,
  output logic        ic_rlast,
  input  logic        ic_rready,
  // LSU
  input  logic        lsu_arvalid,
  input  logic [31:0] lsu_araddr,
  input  logic [2:0]  lsu_arsize,
  output logic        lsu_arready,
  output logic        lsu_rvalid,
  output logic [31:0] lsu_rdata,
  output logic [1:0]  lsu_rresp,
  input  logic        lsu_rready,
  // shared AXI4 master
  output logic        m_arvalid,
  output logic [31:0] m_araddr,
  output logic [7:0]  m_arlen,
  output logic [2:0]  m_arsize,
  output logic [1:0]  m_arburst,
  input  logic        m_arready,
  input  logic        m_rvalid,
  input  logic [31:0] m_rdata,
  input  logic [1:0]  m_rresp,
  input  logic        m_rlast,
  output logic        m_rready,
  // statistics
  output logic [31:0] ic_grant_cnt,
  output logic [31:0] lsu_grant_cnt
);

  arb_state_e  state_q, state_d;
  arb_owner_e  owner_q, owner_d;
  arb_owner_e  winner;
  logic [31:0] araddr_q, araddr_d;
  logic [7:0]  arlen_q, arlen_d;
  logic [2:0]  arsize_q, arsize_d;
  logic [1:0]  arburst_q, arburst_d;
  logic        grant_ic, grant_lsu;
  logic [1:0]  grant_vec;

  ysyx_24070003_arb_grant #(
    .STARVE_MAX (STARVE_MAX)
  ) u_grant (
    .clock         (clock),
    .rstn          (rstn),
    .idle_i        (rstn && (state_q == ST_IDLE)),
    .ic_arvalid_i  (ic_arvalid),
    .lsu_arvalid_i (lsu_arvalid),
    .grant_ic_o    (grant_ic),
    .grant_lsu_o   (grant_lsu),
    .winner_o      (winner)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    araddr_d    = araddr_q;
    arlen_d     = arlen_q;
    arsize_d    = arsize_q;
    arburst_d   = arburst_q;

    ic_arready  = grant_ic;
    lsu_arready = grant_lsu;
    m_arvalid   = 1'b0;
    m_rready    = 1'b0;
    ic_rvalid   = 1'b0;
    ic_rdata    = '0;
    ic_rresp    = '0;
    ic_rlast    = 1'b0;
    lsu_rvalid  = 1'b0;
    lsu_rdata   = '0;
    lsu_rresp   = '0;

    case (state_q)
      ST_IDLE: begin
        if (grant_ic || grant_lsu) begin
          state_d   = ST_ADDR;
          owner_d   = winner;
          araddr_d  = grant_ic ? ic_araddr : lsu_araddr;
          arlen_d   = grant_ic ? ic_arlen  : 8'd0;
          arsize_d  = grant_ic ? SIZE_WORD : lsu_arsize;
          arburst_d = BURST_INCR;
        end
      end
      ST_ADDR: begin
        m_arvalid = 1'b1;
        if (m_arready) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (owner_q == OWN_IC) begin
          m_rready  = ic_rready;
          ic_rvalid = m_rvalid;
          ic_rdata  = m_rdata;
          ic_rresp  = m_rresp;
          ic_rlast  = m_rlast;
        end else begin
          m_rready   = lsu_rready;
          lsu_rvalid = m_rvalid;
          lsu_rdata  = m_rdata;
          lsu_rresp  = m_rresp;
        end
        // Error responses do not end the burst early; only rlast does.
        if (m_rvalid && m_rready && m_rlast) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Keep every output quiet while reset is held, regardless of stale state.
    m_araddr  = rstn ? araddr_q  : '0;
    m_arlen   = rstn ? arlen_q   : '0;
    m_arsize  = rstn ? arsize_q  : '0;
    m_arburst = rstn ? arburst_q : '0;
    if (!rstn) begin
      m_arvalid  = 1'b0;
      m_rready   = 1'b0;
      ic_rvalid  = 1'b0;
      ic_rdata   = '0;
      ic_rresp   = '0;
      ic_rlast   = 1'b0;
      lsu_rvalid = 1'b0;
      lsu_rdata  = '0;
      lsu_rresp  = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      owner_q   <= OWN_IC;
      araddr_q  <= '0;
      arlen_q   <= '0;
      arsize_q  <= '0;
      arburst_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      araddr_q  <= araddr_d;
      arlen_q   <= arlen_d;
      arsize_q  <= arsize_d;
      arburst_q <= arburst_d;
    end
  end

  // Index 0 counts ICACHE grants, index 1 LSU grants; both wrap naturally.
  assign grant_vec = {grant_lsu, grant_ic};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      logic [31:0] cnt_q;
      always_ff @(posedge clock) begin
        if (!rstn) begin
          cnt_q <= '0;
        end else if (grant_vec[gi]) begin
          cnt_q <= cnt_q + 32'd1;
        end
      end
    end
  endgenerate

  assign ic_grant_cnt  = g_cnt[0].cnt_q;
  assign lsu_grant_cnt = g_cnt[1].cnt_q;

endmodule

// File: tb/tb_ysyx_24070003_mem_arbiter.sv
module tb_ysyx_24070003_mem_arbiter;
  import ysyx_24070003_arb_pkg::*;

  logic        clock = 1'b0;
  logic        rstn;
  logic        ic_arvalid, ic_arready, ic_rvalid, ic_rlast, ic_rready;
  logic [31:0] ic_araddr, ic_rdata;
  logic [7:0]  ic_arlen;
  logic [1:0]  ic_rresp;
  logic        lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rready;
  logic [31:0] lsu_araddr, lsu_rdata;
  logic [2:0]  lsu_arsize;
  logic [1:0]  lsu_rresp;
  logic        m_arvalid, m_arready, m_rvalid, m_rlast, m_rready;
  logic [31:0] m_araddr, m_rdata;
  logic [7:0]  m_arlen;
  logic [2:0]  m_arsize;
  logic [1:0]  m_arburst, m_rresp;
  logic [31:0] ic_grant_cnt, lsu_grant_cnt;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clock = ~clock;

  ysyx_24070003_mem_arbiter #(.STARVE_MAX(4)) dut (
    .clock(clock), .rstn(rstn),
    .ic_arvalid(ic_arvalid), .ic_araddr(ic_araddr), .ic_arlen(ic_arlen), .ic_arready(ic_arready),
    .ic_rvalid(ic_rvalid), .ic_rdata(ic_rdata), .ic_rresp(ic_rresp), .ic_rlast(ic_rlast), .ic_rready(ic_rready),
    .lsu_arvalid(lsu_arvalid), .lsu_araddr(lsu_araddr), .lsu_arsize(lsu_arsize), .lsu_arready(lsu_arready),
    .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp), .lsu_rready(lsu_rready),
    .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_arready(m_arready), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .m_rready(m_rready), .ic_grant_cnt(ic_grant_cnt), .lsu_grant_cnt(lsu_grant_cnt)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    ic_arvalid = 0; ic_araddr = '0; ic_arlen = '0; ic_rready = 0;
    lsu_arvalid = 0; lsu_araddr = '0; lsu_arsize = '0; lsu_rready = 0;
    m_arready = 0; m_rvalid = 0; m_rdata = '0; m_rresp = '0; m_rlast = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rstn = 0;
    tick();
    tick();
    rstn = 1;
  endtask

  // Stimulus only: request, grant edge, one-cycle AR handshake; returns in DATA.
  task automatic issue_ar(input logic is_ic, input logic [31:0] addr, input logic [7:0] len);
    if (is_ic) begin
      ic_arvalid = 1; ic_araddr = addr; ic_arlen = len;
    end else begin
      lsu_arvalid = 1; lsu_araddr = addr;
    end
    tick();
    ic_arvalid = 0; lsu_arvalid = 0; m_arready = 1;
    tick();
    m_arready = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rstn = 0;
    ic_arvalid = 1; lsu_arvalid = 1; m_rvalid = 1; m_rdata = 32'hFFFF_FFFF; m_rlast = 1;
    ic_rready = 1; lsu_rready = 1; m_arready = 1;
    tick();
    tick();
    $display("reset: held low two cycles with all requests asserted");
    total_cnt++; if (ic_arready !== 1'b0) $display("FAIL rst_ic_arready: got %b want 0", ic_arready); else pass_cnt++;
    total_cnt++; if (lsu_arready !== 1'b0) $display("FAIL rst_lsu_arready: got %b want 0", lsu_arready); else pass_cnt++;
    total_cnt++; if (m_arvalid !== 1'b0) $display("FAIL rst_m_arvalid: got %b want 0", m_arvalid); else pass_cnt++;
    total_cnt++; if (m_rready !== 1'b0) $display("FAIL rst_m_rready: got %b want 0", m_rready); else pass_cnt++;
    total_cnt++; if ({ic_rvalid, lsu_rvalid} !== 2'b00) $display("FAIL rst_rvalid: got %b want 00", {ic_rvalid, lsu_rvalid}); else pass_cnt++;
    total_cnt++; if ((ic_rdata | lsu_rdata | m_araddr) !== 32'h0) $display("FAIL rst_data: ic_rdata=%h lsu_rdata=%h m_araddr=%h want 0", ic_rdata, lsu_rdata, m_araddr); else pass_cnt++;
    total_cnt++; if ({ic_grant_cnt, lsu_grant_cnt} !== 64'h0) $display("FAIL rst_cnt: ic=%0d lsu=%0d want 0", ic_grant_cnt, lsu_grant_cnt); else pass_cnt++;
    idle_inputs();
    rstn = 1;
    #1;
    total_cnt++; if (dut.state_q !== ST_IDLE) $display("FAIL rst_state: got %0d want IDLE", dut.state_q); else pass_cnt++;
    total_cnt++; if ({m_arvalid, m_arburst, m_arsize, m_arlen} !== 14'h0) $display("FAIL post_rst_ar: got %h want 0", {m_arvalid, m_arburst, m_arsize, m_arlen}); else pass_cnt++;
  endtask

  task automatic test_lsu_load();
    lsu_arvalid = 1; lsu_araddr = 32'h8000_1000; lsu_arsize = 3'd2; lsu_rready = 1;
    #1;
    $display("lsu_load: addr=%h size=%0d", lsu_araddr, lsu_arsize);
    total_cnt++; if ({lsu_arready, ic_arready, m_arvalid} !== 3'b100) $display("FAIL lsu_grant: lsu/ic arready,m_arvalid=%b want 100", {lsu_arready, ic_arready, m_arvalid}); else pass_cnt++;
    tick();
    lsu_arvalid = 0;
    #1;
    total_cnt++; if (m_arvalid !== 1'b1) $display("FAIL lsu_ar_c1: m_arvalid=%b want 1", m_arvalid); else pass_cnt++;
    total_cnt++; if (m_araddr !== 32'h8000_1000) $display("FAIL lsu_araddr: got %h want 80001000", m_araddr); else pass_cnt++;
    total_cnt++; if ({m_arlen, m_arsize, m_arburst} !== {8'd0, 3'd2, 2'b01}) $display("FAIL lsu_arfields: len=%0d size=%0d burst=%0d want 0/2/1", m_arlen, m_arsize, m_arburst); else pass_cnt++;
    tick();
    m_arready = 1;
    #1;
    total_cnt++; if ({m_arvalid, m_araddr} !== {1'b1, 32'h8000_1000}) $display("FAIL lsu_ar_c2: valid=%b addr=%h want 1/80001000", m_arvalid, m_araddr); else pass_cnt++;
    tick();
    m_arready = 0; m_rvalid = 1; m_rdata = 32'h1234_5678; m_rresp = 2'b00; m_rlast = 1;
    #1;
    total_cnt++; if ({m_arvalid, m_rready} !== 2'b01) $display("FAIL lsu_data_hs: m_arvalid,m_rready=%b want 01", {m_arvalid, m_rready}); else pass_cnt++;
    total_cnt++; if ({lsu_rvalid, ic_rvalid} !== 2'b10) $display("FAIL lsu_route: lsu_rvalid,ic_rvalid=%b want 10", {lsu_rvalid, ic_rvalid}); else pass_cnt++;
    total_cnt++; if (lsu_rdata !== 32'h1234_5678) $display("FAIL lsu_rdata: got %h want 12345678", lsu_rdata); else pass_cnt++;
    tick();
    m_rvalid = 0; m_rlast = 0;
    #1;
    total_cnt++; if (dut.state_q !== ST_IDLE) $display("FAIL lsu_done_state: got %0d want IDLE", dut.state_q); else pass_cnt++;
    total_cnt++; if (lsu_grant_cnt !== 32'd1) $display("FAIL lsu_cnt: got %0d want 1", lsu_grant_cnt); else pass_cnt++;
  endtask

  task automatic test_ic_burst();
    ic_arvalid = 1; ic_araddr = 32'h3000_0000; ic_arlen = 8'd3; ic_rready = 1; lsu_rready = 1;
    #1;
    $display("ic_burst: addr=%h arlen=%0d", ic_araddr, ic_arlen);
    total_cnt++; if ({ic_arready, lsu_arready} !== 2'b10) $display("FAIL ic_grant: ic,lsu arready=%b want 10", {ic_arready, lsu_arready}); else pass_cnt++;
    tick();
    ic_arvalid = 0; m_arready = 1;
    #1;
    total_cnt++; if ({m_arvalid, m_araddr} !== {1'b1, 32'h3000_0000}) $display("FAIL ic_ar: valid=%b addr=%h want 1/30000000", m_arvalid, m_araddr); else pass_cnt++;
    total_cnt++; if ({m_arlen, m_arsize, m_arburst} !== {8'd3, 3'd2, 2'b01}) $display("FAIL ic_arfields: len=%0d size=%0d burst=%0d want 3/2/1", m_arlen, m_arsize, m_arburst); else pass_cnt++;
    tick();
    m_arready = 0;
    for (int b = 0; b < 4; b++) begin
      m_rvalid = 1; m_rdata = 32'hC0DE_0000 + b; m_rlast = (b == 3);
      #1;
      $display("ic_burst: beat %0d data=%h last=%b", b, ic_rdata, ic_rlast);
      total_cnt++; if ({ic_rvalid, lsu_rvalid, ic_rlast} !== {2'b10, (b == 3)}) $display("FAIL ic_beat%0d_ctl: ic_rvalid,lsu_rvalid,rlast=%b want 10%b", b, {ic_rvalid, lsu_rvalid, ic_rlast}, (b == 3)); else pass_cnt++;
      total_cnt++; if (ic_rdata !== 32'hC0DE_0000 + b) $display("FAIL ic_beat%0d_data: got %h want %h", b, ic_rdata, 32'hC0DE_0000 + b); else pass_cnt++;
      tick();
    end
    m_rvalid = 0; m_rlast = 0;
    #1;
    total_cnt++; if (dut.state_q !== ST_IDLE) $display("FAIL ic_done_state: got %0d want IDLE", dut.state_q); else pass_cnt++;
    total_cnt++; if (ic_grant_cnt !== 32'd1) $display("FAIL ic_cnt: got %0d want 1", ic_grant_cnt); else pass_cnt++;
  endtask

  task automatic test_rready_stall();
    logic [31:0] got[$];
    int          sidx;
    sidx = 0;
    issue_ar(1'b1, 32'h3000_0040, 8'd3);
    for (int c = 0; c < 7; c++) begin
      ic_rready = !(c >= 1 && c <= 3);
      m_rvalid = 1; m_rdata = 32'hB000_0000 + sidx; m_rlast = (sidx == 3);
      #1;
      $display("rready_stall: cycle %0d ic_rready=%b m_rready=%b data=%h", c, ic_rready, m_rready, ic_rdata);
      total_cnt++; if (m_rready !== ic_rready) $display("FAIL stall_c%0d_rready: m_rready=%b want %b", c, m_rready, ic_rready); else pass_cnt++;
      if (ic_rvalid && ic_rready) got.push_back(ic_rdata);
      if (m_rvalid && m_rready) sidx++;
      tick();
    end
    m_rvalid = 0; m_rlast = 0; ic_rready = 1;
    #1;
    total_cnt++; if (got.size() !== 4) $display("FAIL stall_beats: got %0d beats want 4", got.size()); else pass_cnt++;
    for (int i = 0; i < got.size(); i++) begin
      total_cnt++; if (got[i] !== 32'hB000_0000 + i) $display("FAIL stall_beat%0d: got %h want %h", i, got[i], 32'hB000_0000 + i); else pass_cnt++;
    end
    total_cnt++; if ({dut.state_q == ST_IDLE, ic_grant_cnt} !== {1'b1, 32'd2}) $display("FAIL stall_end: idle=%b ic_cnt=%0d want 1/2", dut.state_q == ST_IDLE, ic_grant_cnt); else pass_cnt++;
  endtask

  task automatic test_error_resp();
    lsu_arsize = 3'd2; lsu_rready = 1;
    issue_ar(1'b0, 32'h8000_2000, 8'd0);
    m_rvalid = 1; m_rdata = 32'h0BAD_F00D; m_rresp = 2'b10; m_rlast = 1;
    #1;
    $display("error_resp: lsu_rresp=%b lsu_rvalid=%b", lsu_rresp, lsu_rvalid);
    total_cnt++; if ({lsu_rvalid, lsu_rresp} !== 3'b110) $display("FAIL err_rresp: rvalid,rresp=%b want 110", {lsu_rvalid, lsu_rresp}); else pass_cnt++;
    tick();
    m_rvalid = 0; m_rresp = 0; m_rlast = 0;
    #1;
    total_cnt++; if (dut.state_q !== ST_IDLE) $display("FAIL err_state: got %0d want IDLE", dut.state_q); else pass_cnt++;
    total_cnt++; if (lsu_grant_cnt !== 32'd2) $display("FAIL err_cnt: got %0d want 2", lsu_grant_cnt); else pass_cnt++;
  endtask

  task automatic test_starvation();
    logic [9:0] exp_ic;
    exp_ic = 10'b10_0001_0000;  // grant 4 and grant 9 go to ICACHE
    do_reset();
    ic_arvalid = 1; ic_araddr = 32'h3000_1000; ic_arlen = 8'd0;
    lsu_arvalid = 1; lsu_araddr = 32'h8000_4000; lsu_arsize = 3'd2;
    ic_rready = 1; lsu_rready = 1;
    for (int i = 0; i < 10; i++) begin
      #1;
      $display("starvation: grant %0d ic=%b lsu=%b starve=%0d", i, ic_arready, lsu_arready, dut.u_grant.starve_q);
      total_cnt++; if ({ic_arready, lsu_arready} !== {exp_ic[i], !exp_ic[i]}) $display("FAIL starve_g%0d: ic,lsu=%b want %b%b", i, {ic_arready, lsu_arready}, exp_ic[i], !exp_ic[i]); else pass_cnt++;
      total_cnt++; if (int'(dut.u_grant.starve_q) !== i % 5) $display("FAIL starve_cnt%0d: got %0d want %0d", i, dut.u_grant.starve_q, i % 5); else pass_cnt++;
      tick();
      m_arready = 1;
      tick();
      m_arready = 0; m_rvalid = 1; m_rlast = 1; m_rdata = 32'h5000_0000 + i;
      #1;
      total_cnt++; if ({ic_arready, lsu_arready} !== 2'b00) $display("FAIL starve_busy%0d: ic,lsu arready=%b want 00", i, {ic_arready, lsu_arready}); else pass_cnt++;
      tick();
      m_rvalid = 0; m_rlast = 0;
    end
    ic_arvalid = 0; lsu_arvalid = 0;
    #1;
    total_cnt++; if ({ic_grant_cnt, lsu_grant_cnt} !== {32'd2, 32'd8}) $display("FAIL starve_totals: ic=%0d lsu=%0d want 2/8", ic_grant_cnt, lsu_grant_cnt); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    ic_rready = 1; lsu_rready = 1;
    issue_ar(1'b1, 32'h3000_0100, 8'd3);
    m_rvalid = 1; m_rdata = 32'hD000_0000; m_rlast = 0;
    tick();
    m_rdata = 32'hD000_0001;
    rstn = 0;
    tick();
    $display("reset_mid: reset applied on beat 2");
    total_cnt++; if (dut.state_q !== ST_IDLE) $display("FAIL rmid_state: got %0d want IDLE", dut.state_q); else pass_cnt++;
    total_cnt++; if ({m_arvalid, m_rready, ic_rvalid, lsu_rvalid, ic_arready, lsu_arready} !== 6'b0) $display("FAIL rmid_ctl: got %b want 000000", {m_arvalid, m_rready, ic_rvalid, lsu_rvalid, ic_arready, lsu_arready}); else pass_cnt++;
    total_cnt++; if ((ic_rdata | m_araddr) !== 32'h0 || ic_grant_cnt !== 32'd0) $display("FAIL rmid_data: ic_rdata=%h m_araddr=%h ic_cnt=%0d want 0", ic_rdata, m_araddr, ic_grant_cnt); else pass_cnt++;
    rstn = 1;
    #1;
    total_cnt++; if ({m_rready, ic_rvalid} !== 2'b00) $display("FAIL rmid_idle_route: m_rready,ic_rvalid=%b want 00", {m_rready, ic_rvalid}); else pass_cnt++;
    m_rvalid = 0;
    lsu_arsize = 3'd2;
    issue_ar(1'b0, 32'h8000_3000, 8'd0);
    m_rvalid = 1; m_rdata = 32'h5555_AAAA; m_rlast = 1;
    #1;
    $display("reset_mid: follow-up lsu data=%h", lsu_rdata);
    total_cnt++; if ({lsu_rvalid, lsu_rdata} !== {1'b1, 32'h5555_AAAA}) $display("FAIL rmid_lsu: rvalid=%b data=%h want 1/5555aaaa", lsu_rvalid, lsu_rdata); else pass_cnt++;
    tick();
    m_rvalid = 0; m_rlast = 0;
    #1;
    total_cnt++; if ({dut.state_q == ST_IDLE, lsu_grant_cnt} !== {1'b1, 32'd1}) $display("FAIL rmid_end: idle=%b lsu_cnt=%0d want 1/1", dut.state_q == ST_IDLE, lsu_grant_cnt); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_lsu_load();
    test_ic_burst();
    test_rready_stall();
    test_error_resp();
    test_starvation();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/ysyx_24070003_mem_arbiter.md
YSYX_24070003_MEM_ARBITER -- requirements
Module: ysyx_24070003_mem_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 4: consecutive ICACHE losses after which ICACHE wins the next grant.
REQ-002 clock  in  1  system clock; all state updates on its rising edge.
REQ-003 rstn  in  1  reset, synchronous, active-low.
REQ-004 ic_arvalid / ic_araddr / ic_arlen  in  1/32/8  ICACHE refill request, address and burst length (beats-1).
REQ-005 ic_arready  out  1  ICACHE request accepted this cycle.
REQ-006 ic_rvalid / ic_rdata / ic_rresp / ic_rlast  out  1/32/2/1  ICACHE read data beat.
REQ-007 ic_rready  in  1  ICACHE accepts a beat.
REQ-008 lsu_arvalid / lsu_araddr / lsu_arsize  in  1/32/3  LSU single-beat load request.
REQ-009 lsu_arready  out  1  LSU request accepted this cycle.
REQ-010 lsu_rvalid / lsu_rdata / lsu_rresp  out  1/32/2  LSU load data.
REQ-011 lsu_rready  in  1  LSU accepts data.
REQ-012 m_arvalid / m_araddr / m_arlen / m_arsize / m_arburst  out  1/32/8/3/2  shared AXI4 AR channel.
REQ-013 m_arready  in  1  slave accepts AR.
REQ-014 m_rvalid / m_rdata / m_rresp / m_rlast  in  1/32/2/1  shared AXI4 R channel.
REQ-015 m_rready  out  1  R-channel ready toward slave.
REQ-016 ic_grant_cnt / lsu_grant_cnt  out  32/32  grant counters per requester.

Function
REQ-017 FSM states: IDLE, ADDR, DATA; owner register holds IC or LSU.
REQ-018 IDLE: grant when any arvalid is high; lsu_arvalid wins over ic_arvalid unless starve counter == STARVE_MAX, in which case ICACHE wins.
REQ-019 Grant cycle: winner's arready = 1 combinationally; loser's arready = 0; AR fields latched; next state ADDR.
REQ-020 ADDR: m_arvalid = 1 from registered fields, held stable until m_arready; on m_arvalid & m_arready go to DATA.
REQ-021 ICACHE AR: m_arlen = ic_arlen, m_arsize = 3'b010, m_arburst = 2'b01.
REQ-022 LSU AR: m_arlen = 0, m_arsize = lsu_arsize, m_arburst = 2'b01.
REQ-023 DATA: m_rvalid/m_rdata/m_rresp/m_rlast routed to the owner; m_rready = owner's rready; non-owner rvalid = 0.
REQ-024 DATA exits to IDLE on m_rvalid & m_rready & m_rlast; the LSU also exits only on rlast.
REQ-025 Error rresp passes through unchanged; no retry and no early exit.
REQ-026 IDLE and ADDR: m_rready = 0; all requester rvalid = 0.
REQ-027 Minimum of one IDLE cycle between transactions; request accepted at cycle N gives m_arvalid at N+1.
REQ-028 Starve counter (width clog2(STARVE_MAX+1)):
  - increments (saturating) on an LSU grant while ic_arvalid is high;
  - clears on an ICACHE grant;
  - otherwise holds.
REQ-029 Grant counters increment by 1 per grant cycle of their requester and wrap from 0xFFFFFFFF to 0.
REQ-030 A requester deasserting arvalid before arready is a protocol violation; behaviour is undefined and no check is performed.

Reset
REQ-031 rstn low at a rising edge: state = IDLE, starve counter = 0, grant counters = 0, latched AR fields = 0.
REQ-032 During and directly after reset: all valid/ready outputs = 0 and all data outputs = 0.
REQ-033 Reset mid-transaction abandons the burst with no drain; the slave is reset by the same rstn.

Structure
REQ-034 Shared package ysyx_24070003_arb_pkg holds the state enum, owner enum, BURST_INCR = 2'b01 and SIZE_WORD = 3'b010.
REQ-035 One sub-module, ysyx_24070003_arb_grant, holds the priority decision and the starve counter; FSM, muxing and counters stay in the top.

Verification
REQ-036 LSU-only load at 0x80001000, size 2, slave 2-cycle arready delay -> m_arvalid held 2 cycles, lsu_rdata matches, lsu_grant_cnt = 1.
REQ-037 ICACHE burst at 0x30000000, arlen 3 -> 4 beats delivered in order only to ICACHE, rlast on beat 4, FSM back to IDLE.
REQ-038 Both requesting continuously, STARVE_MAX = 4 -> grant order LSU x4, IC, LSU x4, IC; starve counter never exceeds 4.
REQ-039 ic_rready low for 3 cycles mid-burst -> m_rready low for those 3 cycles, no beat lost or duplicated.
REQ-040 rstn low during DATA beat 2 -> next cycle all outputs 0, state IDLE; a new LSU request is served normally.
REQ-041 m_rresp = 2'b10 on LSU beat -> lsu_rresp = 2'b10; arbiter returns to IDLE.
